// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int INSTR_W = 32;

  // MIPS instruction field positions
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int IMM_W  = 16;
  localparam int JIDX_W = 26;

endpackage

// File: rtl/npc_gen.sv
// Combinational next-PC generator: sequential, branch and jump targets.
module npc_gen
  import ifu_pkg::*;
(
  input  logic [31:0]        pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               pcsrc,
  input  logic               jump,
  output logic [31:0]        pcplus4,
  output logic [31:0]        npc
);

  logic [31:0] branch_off;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic        unused_op;

  // The opcode field plays no part in target arithmetic
  assign unused_op = ^instr[OP_HI:OP_LO];

  // Compute all candidate targets, jump wins over branch
  always_comb begin
    pcplus4    = pc + 32'd4;
    branch_off = {{(32 - IMM_W - 2){instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};
    branch_tgt = pcplus4 + branch_off;
    jump_tgt   = {pcplus4[31:28], instr[JIDX_W-1:0], 2'b00};
    if (jump) begin
      npc = jump_tgt;
    end else if (pcsrc) begin
      npc = branch_tgt;
    end else begin
      npc = pcplus4;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Multi-cycle instruction fetch unit: owns the PC, issues one memory read
// at a time, holds the fetched word for decode and advances on retire.
module ifetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               pcsrc,
  input  logic               jump,
  output logic [31:0]        pc,
  output logic [31:0]        pcplus4,
  output logic [31:0]        instret
);

  ifu_state_t  state;
  logic [31:0] npc;

  npc_gen u_npc_gen (
    .pc      (pc),
    .instr   (instr),
    .pcsrc   (pcsrc),
    .jump    (jump),
    .pcplus4 (pcplus4),
    .npc     (npc)
  );

  // The address bus always shows the registered PC
  assign imem_addr = pc;

  // Fetch FSM with registered request/valid outputs, PC, instruction and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      instret     <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ready) begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc          <= npc;
            instret     <= instret + 32'd1;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= REQ;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
